// File: rtl/irq_csr_ctrl.sv
// irq_csr_ctrl: machine-mode CSR file, free-running counters and interrupt
// entry/return sequencer for a small single-hart core.
// Optional feature macro: IRQ_CSR_CTRL_VECTORED_EN (vectored trap entry when
// mtvec[0]=1). Without it mtvec[0] reads 0 and every trap uses the direct target.
module irq_csr_ctrl #(
    parameter int NUM_IRQ = 4,   // external interrupt lines, 1..16
    parameter int CNT_W   = 32   // counter width, 32..64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               csr_we,
    input  logic [11:0]        csr_addr,
    input  logic [31:0]        csr_wdata,
    output logic [31:0]        csr_rdata,
    input  logic               retire,
    input  logic               mret,
    output logic               trap_req,
    input  logic               trap_ack,
    input  logic [31:0]        ack_pc,
    output logic               redirect,
    output logic [31:0]        redirect_pc
);

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MINSTRET = 12'hB02;
    localparam logic [11:0] A_MTIMECMP = 12'h7C0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_ENTER
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic               r_mstatus_mie;
    logic               r_mstatus_mpie;
    logic [31:0]        r_mie;
    logic [31:0]        r_mtvec;
    logic [31:0]        r_mepc;
    logic [31:0]        r_mcause;
    logic [CNT_W-1:0]   r_mcycle;
    logic [CNT_W-1:0]   r_minstret;
    logic [CNT_W-1:0]   r_mtimecmp;
    logic               r_mret_pulse;

    logic               w_timer_pend;
    logic [31:0]        w_mip;
    logic [31:0]        w_pend_en;
    logic               w_any_pend;
    logic [4:0]         w_sel_code;
    logic               w_take_trap;
    logic               w_take_mret;
    logic [31:0]        w_trap_pc;

    assign w_timer_pend = (r_mcycle >= r_mtimecmp);

    // Build the live pending vector: timer at bit 7, external lines from bit 16.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_mip    = '0;
        w_mip[7] = w_timer_pend;
        for (int i = 0; i < NUM_IRQ; i++) begin
            w_mip[16+i] = irq_in[i];
        end
    end

    assign w_pend_en  = w_mip & r_mie;
    assign w_any_pend = |w_pend_en;

    // Pick the cause code: timer is the fallback, higher external index overrides.
    always_comb begin
        w_sel_code = 5'd7;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (w_pend_en[16+i]) begin
                w_sel_code = 5'(16 + i);
            end
        end
    end

    // Trap sequencer state register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; a withdrawn request takes precedence over a late ack so
    // a trap is never entered with a stale cause.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (r_mstatus_mie && w_any_pend && !mret) begin
                    w_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (!w_any_pend || !r_mstatus_mie) begin
                    w_next = ST_IDLE;
                end else if (trap_ack) begin
                    w_next = ST_ENTER;
                end
            end
            ST_ENTER: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign w_take_trap = (r_state == ST_REQ) && (w_next == ST_ENTER);
    assign w_take_mret = (r_state == ST_IDLE) && mret;

    // CSR state: counters, software writes, then trap/mret updates which win.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mie          <= '0;
            r_mtvec        <= '0;
            r_mepc         <= '0;
            r_mcause       <= '0;
            r_mcycle       <= '0;
            r_minstret     <= '0;
            r_mtimecmp     <= '1;
            r_mret_pulse   <= 1'b0;
        end else begin
            r_mcycle     <= r_mcycle + 1'b1;
            if (retire) begin
                r_minstret <= r_minstret + 1'b1;
            end
            r_mret_pulse <= w_take_mret;

            if (csr_we) begin
                case (csr_addr)
                    A_MSTATUS: begin
                        r_mstatus_mie  <= csr_wdata[3];
                        r_mstatus_mpie <= csr_wdata[7];
                    end
                    A_MIE: r_mie <= csr_wdata;
`ifdef IRQ_CSR_CTRL_VECTORED_EN
                    A_MTVEC: r_mtvec <= {csr_wdata[31:2], 1'b0, csr_wdata[0]};
`else
                    A_MTVEC: r_mtvec <= {csr_wdata[31:2], 2'b00};
`endif
                    A_MEPC:     r_mepc     <= {csr_wdata[31:2], 2'b00};
                    A_MCAUSE:   r_mcause   <= csr_wdata;
                    A_MCYCLE:   r_mcycle   <= CNT_W'(csr_wdata);
                    A_MINSTRET: r_minstret <= CNT_W'(csr_wdata);
                    A_MTIMECMP: r_mtimecmp <= CNT_W'(csr_wdata);
                    default: ;
                endcase
            end

            if (w_take_trap) begin
                r_mepc         <= ack_pc & 32'hFFFF_FFFC;
                r_mcause       <= {1'b1, 26'b0, w_sel_code};
                r_mstatus_mpie <= r_mstatus_mie;
                r_mstatus_mie  <= 1'b0;
            end else if (w_take_mret) begin
                r_mstatus_mie  <= r_mstatus_mpie;
                r_mstatus_mpie <= 1'b1;
            end
        end
    end

    // Trap entry target, optionally offset by the latched cause code.
    always_comb begin
        w_trap_pc = {r_mtvec[31:2], 2'b00};
`ifdef IRQ_CSR_CTRL_VECTORED_EN
        if (r_mtvec[0]) begin
            w_trap_pc = {r_mtvec[31:2], 2'b00} + {25'b0, r_mcause[4:0], 2'b00};
        end
`endif
    end

    assign trap_req    = (r_state == ST_REQ);
    assign redirect    = (r_state == ST_ENTER) || r_mret_pulse;
    assign redirect_pc = r_mret_pulse ? r_mepc : w_trap_pc;

    // CSR read mux; unmapped addresses read zero.
    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            A_MSTATUS:  csr_rdata = {24'b0, r_mstatus_mpie, 3'b0, r_mstatus_mie, 3'b0};
            A_MIE:      csr_rdata = r_mie;
            A_MTVEC:    csr_rdata = r_mtvec;
            A_MEPC:     csr_rdata = r_mepc;
            A_MCAUSE:   csr_rdata = r_mcause;
            A_MIP:      csr_rdata = w_mip;
            A_MCYCLE:   csr_rdata = r_mcycle[31:0];
            A_MINSTRET: csr_rdata = r_minstret[31:0];
            A_MTIMECMP: csr_rdata = r_mtimecmp[31:0];
            default:    csr_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_csr_ctrl.sv
// Directed bench for irq_csr_ctrl: expectations are queued as stimulus is
// applied and popped when the corresponding DUT output is sampled.
module tb_irq_csr_ctrl;

    localparam int NUM_IRQ = 4;

    logic               clk;
    logic               rst;
    logic [NUM_IRQ-1:0] irq_in;
    logic               csr_we;
    logic [11:0]        csr_addr;
    logic [31:0]        csr_wdata;
    logic [31:0]        csr_rdata;
    logic               retire;
    logic               mret;
    logic               trap_req;
    logic               trap_ack;
    logic [31:0]        ack_pc;
    logic               redirect;
    logic [31:0]        redirect_pc;

    irq_csr_ctrl #(.NUM_IRQ(NUM_IRQ), .CNT_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .irq_in      (irq_in),
        .csr_we      (csr_we),
        .csr_addr    (csr_addr),
        .csr_wdata   (csr_wdata),
        .csr_rdata   (csr_rdata),
        .retire      (retire),
        .mret        (mret),
        .trap_req    (trap_req),
        .trap_ack    (trap_ack),
        .ack_pc      (ack_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic push(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        n_total++;
        if (sb.size() == 0) begin
            $error("FAIL scoreboard_empty: observed %h, no expected value queued", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) n_pass++;
            else $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
        end
    endtask

    // One clock: inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
        csr_we    = 1'b1;
        csr_addr  = a;
        csr_wdata = d;
        tick();
        csr_we    = 1'b0;
    endtask

    task automatic csr_rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
        csr_addr = a;
        push(tag, exp);
        #1;
        check(csr_rdata);
    endtask

    task automatic expect_bit(input string tag, input logic obs, input logic exp);
        push(tag, {31'b0, exp});
        check({31'b0, obs});
    endtask

    // Bounded wait for the request; an expired budget shows up as a failed check.
    task automatic wait_req(input string tag);
        for (int i = 0; i < 60; i++) begin
            if (trap_req) break;
            tick();
        end
        expect_bit(tag, trap_req, 1'b1);
    endtask

    task automatic ack(input logic [31:0] pc);
        trap_ack = 1'b1;
        ack_pc   = pc;
        tick();
        trap_ack = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        irq_in    = '0;
        csr_we    = 1'b0;
        csr_addr  = '0;
        csr_wdata = '0;
        retire    = 1'b0;
        mret      = 1'b0;
        trap_ack  = 1'b0;
        ack_pc    = '0;

        // Reset state
        #12;
        expect_bit("rst_trap_req", trap_req, 1'b0);
        expect_bit("rst_redirect", redirect, 1'b0);
        csr_rd("rst_mtimecmp", 12'h7C0, 32'hFFFF_FFFF);
        csr_rd("rst_mstatus", 12'h300, 32'h0);
        tick();
        rst = 1'b0;
        tick();

        // Basic CSR behaviour
        csr_rd("unmapped_read", 12'h123, 32'h0);
        csr_wr(12'h344, 32'hFFFF_FFFF);
        csr_rd("mip_write_ignored", 12'h344, 32'h0);
        csr_wr(12'h341, 32'h0000_1237);
        csr_rd("mepc_low_bits", 12'h341, 32'h0000_1234);
        retire = 1'b1;
        csr_wr(12'hB02, 32'h0);
        tick();
        tick();
        tick();
        retire = 1'b0;
        csr_rd("minstret_count", 12'hB02, 32'd3);

        // Direct-mode trap entry from irq_in[0]
        csr_wr(12'h305, 32'h100);
        csr_wr(12'h304, 32'h0001_0000);
        csr_wr(12'h300, 32'h8);
        irq_in = 4'b0001;
        tick();
        expect_bit("ext0_trap_req", trap_req, 1'b1);
        csr_rd("ext0_mip", 12'h344, 32'h0001_0000);
        ack(32'h40);
        expect_bit("enter_redirect", redirect, 1'b1);
        push("enter_redirect_pc", 32'h100);
        check(redirect_pc);
        csr_rd("enter_mepc", 12'h341, 32'h40);
        csr_rd("enter_mcause", 12'h342, 32'h8000_0010);
        csr_rd("enter_mstatus", 12'h300, 32'h80);
        tick();
        expect_bit("after_enter_redirect", redirect, 1'b0);
        expect_bit("after_enter_no_req", trap_req, 1'b0);
        irq_in = '0;

        // Return via mret
        mret = 1'b1;
        tick();
        mret = 1'b0;
        expect_bit("mret_redirect", redirect, 1'b1);
        push("mret_redirect_pc", 32'h40);
        check(redirect_pc);
        csr_rd("mret_mstatus", 12'h300, 32'h88);
        tick();
        expect_bit("mret_pulse_end", redirect, 1'b0);

        // Priority: external 1 beats external 0 and timer; mstatus write during ack loses
        csr_wr(12'h300, 32'h0);
        csr_wr(12'h304, 32'h0003_0080);
        csr_wr(12'h7C0, 32'h0);
        irq_in = 4'b0011;
        csr_wr(12'h300, 32'h8);
        wait_req("prio_trap_req");
        csr_we    = 1'b1;
        csr_addr  = 12'h300;
        csr_wdata = 32'h8;
        ack(32'h80);
        csr_we = 1'b0;
        csr_rd("prio_mcause", 12'h342, 32'h8000_0011);
        csr_rd("prio_mepc", 12'h341, 32'h80);
        csr_rd("ack_overrides_mstatus_wr", 12'h300, 32'h80);
        tick();
        irq_in = '0;
        csr_wr(12'h7C0, 32'hFFFF_FFFF);

        // Withdrawn request
        csr_wr(12'h304, 32'h0001_0000);
        csr_wr(12'h300, 32'h8);
        irq_in = 4'b0001;
        wait_req("withdraw_req");
        irq_in = '0;
        tick();
        expect_bit("withdraw_req_falls", trap_req, 1'b0);
        ack(32'h200);
        expect_bit("late_ack_no_redirect", redirect, 1'b0);
        tick();
        expect_bit("late_ack_no_redirect2", redirect, 1'b0);
        csr_rd("withdraw_mepc_kept", 12'h341, 32'h80);

        // Timer compare and reset during REQ
        csr_wr(12'h300, 32'h0);
        csr_wr(12'h304, 32'h80);
        csr_wr(12'h7C0, 32'd20);
        csr_wr(12'hB00, 32'd0);
        csr_wr(12'h300, 32'h8);
        wait_req("timer_req");
        // Pending once mcycle==20; the FSM registers the request one edge later.
        csr_rd("timer_req_mcycle", 12'hB00, 32'd21);
        rst = 1'b1;
        #1;
        expect_bit("rst_in_req_trap_req", trap_req, 1'b0);
        expect_bit("rst_in_req_redirect", redirect, 1'b0);
        csr_rd("rst_in_req_mepc", 12'h341, 32'h0);
        csr_rd("rst_in_req_mcause", 12'h342, 32'h0);
        tick();
        rst = 1'b0;
        tick();

        // Vectored vs direct timer entry
        csr_wr(12'h305, 32'h101);
`ifdef IRQ_CSR_CTRL_VECTORED_EN
        csr_rd("mtvec_mode_bit", 12'h305, 32'h101);
`else
        csr_rd("mtvec_mode_bit", 12'h305, 32'h100);
`endif
        csr_wr(12'h304, 32'h80);
        csr_wr(12'h7C0, 32'h0);
        csr_wr(12'h300, 32'h8);
        wait_req("vec_timer_req");
        ack(32'h44);
        expect_bit("vec_redirect", redirect, 1'b1);
`ifdef IRQ_CSR_CTRL_VECTORED_EN
        push("vec_redirect_pc", 32'h11C);
`else
        push("vec_redirect_pc", 32'h100);
`endif
        check(redirect_pc);
        csr_rd("vec_mcause", 12'h342, 32'h8000_0007);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/irq_csr_ctrl.md
IRQ_CSR_CTRL -- requirements
Module: irq_csr_ctrl

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 4, number of external interrupt lines (legal 1..16).
REQ-002 SHALL have parameter CNT_W, default 32, width of cycle/instret/timer counters (legal 32..64; only low 32 bits CSR-visible).
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port irq_in  in  NUM_IRQ  level-sensitive external interrupt requests.
REQ-006 SHALL have ports csr_we  in  1,  csr_addr  in  12,  csr_wdata  in  32: CSR write strobe, address, data.
REQ-007 SHALL have port csr_rdata  out  32  combinational read data for csr_addr; 0 for unmapped addresses.
REQ-008 SHALL have ports retire  in  1 (instruction retired) and mret  in  1 (MRET in execute).
REQ-009 SHALL have ports trap_req  out  1,  trap_ack  in  1,  ack_pc  in  32: interrupt request to the pipeline, acceptance, PC to save.
REQ-010 SHALL have ports redirect  out  1,  redirect_pc  out  32: one-cycle fetch redirect pulse and target.

Function
REQ-011 SHALL map CSRs: 0x300 mstatus (bit3 MIE, bit7 MPIE), 0x304 mie, 0x305 mtvec, 0x341 mepc, 0x342 mcause, 0x344 mip, 0xB00 mcycle, 0xB02 minstret, 0x7C0 mtimecmp.
REQ-012 SHALL apply csr_we writes at the next rising edge; mip and writes to unmapped addresses are ignored; mepc[1:0] and mtvec[1] always read 0.
REQ-013 SHALL form mip combinationally: bit7 = timer pending (mcycle >= mtimecmp), bit16+i = irq_in[i]; all other bits 0.
REQ-014 SHALL increment mcycle every cycle and minstret on each cycle retire=1, both wrapping modulo 2^CNT_W; a same-cycle CSR write wins over the increment.
REQ-015 SHALL select the pending enabled source (mip & mie nonzero) with priority: highest external index first, timer last.
REQ-016 SHALL run a 3-state FSM: IDLE, REQ, ENTER.
REQ-017 IDLE->REQ when MIE=1, a pending enabled source exists, and mret=0; trap_req SHALL be 1 exactly while in REQ.
REQ-018 REQ->ENTER on trap_ack=1; REQ->IDLE if the selected source deasserts or MIE clears before trap_ack (request withdrawn, no state change).
REQ-019 In ENTER (one cycle): mepc<=ack_pc captured at the ack edge, mcause<={1'b1, cause code latched at ack}, MPIE<=MIE, MIE<=0, redirect=1; then ENTER->IDLE.
REQ-020 redirect_pc SHALL be {mtvec[31:2],2'b00} in direct mode.
REQ-021 On mret=1 in IDLE: MIE<=MPIE, MPIE<=1, redirect=1 for one cycle, redirect_pc=mepc; mret in REQ or ENTER SHALL be ignored.
REQ-022 A CSR write to mstatus in the same cycle as ENTER or mret SHALL be overridden by the trap/mret update.
REQ-023 trap_ack outside REQ SHALL be ignored.

Reset
REQ-024 On rst=1 (asynchronous): FSM=IDLE; mstatus, mie, mtvec, mepc, mcause, mcycle, minstret = 0; mtimecmp = all ones; trap_req=0, redirect=0.
REQ-025 Reset asserted mid-REQ or mid-ENTER SHALL abort the trap with no mepc/mcause update surviving.

Configuration
REQ-026 Macro IRQ_CSR_CTRL_VECTORED_EN: when defined, mtvec[0]=1 selects vectored mode with redirect_pc = {mtvec[31:2],2'b00} + 4*cause code for interrupt entry; when undefined, mtvec[0] is read-only 0 and all traps use the direct target.

Verification
REQ-027 Write mtvec=0x100, mie=bit16, mstatus=0x8; raise irq_in[0] -> trap_req=1; trap_ack with ack_pc=0x40 -> next cycle redirect=1, redirect_pc=0x100, mepc=0x40, mcause=0x80000010, mstatus=0x80.
REQ-028 After REQ-027, pulse mret -> redirect_pc=0x40, mstatus=0x88.
REQ-029 mie=0x30080, irq_in=0b0011, timer pending -> mcause code 17 (external 1 wins).
REQ-030 Enter REQ, drop irq_in before trap_ack -> trap_req falls next cycle, mepc unchanged; then trap_ack=1 -> no redirect.
REQ-031 mtimecmp=20, mie=0x80, MIE=1 -> trap_req rises when mcycle reaches 20; assert rst during REQ -> all outputs 0 immediately.
REQ-032 With VECTORED_EN, mtvec=0x101, timer trap -> redirect_pc=0x11C; without it mtvec reads 0x100 and redirect_pc=0x100.
